// File: rtl/exh_sweep_ctrl_if.sv
// rtl/exh_sweep_ctrl_if.sv - host and function-pair signal bundle for exh_sweep_ctrl
interface exh_sweep_ctrl_if #(
    parameter int N = 2
);
    // host controls
    logic         start;
    logic         abort;
    // outputs of the two implementations under comparison
    logic         s_in;
    logic         t_in;
    // vector driven to both implementations
    logic [N-1:0] vec;
    // sweep status and results
    logic         busy;
    logic         done;
    logic         pass;
    logic [N:0]   err_cnt;
    logic         fail_valid;
    logic [N-1:0] first_fail;

    // master: the host plus the pair of function blocks
    modport master (
        output start, abort, s_in, t_in,
        input  vec, busy, done, pass, err_cnt, fail_valid, first_fail
    );

    // slave: the sweep controller
    modport slave (
        input  start, abort, s_in, t_in,
        output vec, busy, done, pass, err_cnt, fail_valid, first_fail
    );
endinterface

// File: rtl/exh_sweep_ctrl.sv
// rtl/exh_sweep_ctrl.sv - exhaustive sweep comparator of two implementations; EXH_SWEEP_GRAY_EN selects Gray vector order
module exh_sweep_ctrl #(
    parameter int N = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    exh_sweep_ctrl_if.slave   bus
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DRIVE  = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    localparam logic [N-1:0] IDX_LAST = {N{1'b1}};
    localparam logic [N-1:0] IDX_ONE  = {{(N-1){1'b0}}, 1'b1};
    localparam logic [N:0]   ERR_ONE  = {{N{1'b0}}, 1'b1};

    state_t       state_q,      state_d;
    logic [N-1:0] idx_q,        idx_d;
    logic [N-1:0] vec_q,        vec_d;
    logic         busy_q,       busy_d;
    logic         done_q,       done_d;
    logic         pass_q,       pass_d;
    logic [N:0]   err_cnt_q,    err_cnt_d;
    logic         fail_valid_q, fail_valid_d;
    logic [N-1:0] first_fail_q, first_fail_d;
    logic         mismatch;

    // Sweep index to driven vector: Gray order keeps successive vectors one bit apart.
    function automatic logic [N-1:0] idx_to_vec(input logic [N-1:0] idx);
`ifdef EXH_SWEEP_GRAY_EN
        return idx ^ (idx >> 1);
`else
        return idx;
`endif
    endfunction

    // Next-state and next-output computation; abort beats the SAMPLE compare, start beats abort when idle.
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        busy_d       = busy_q;
        done_d       = done_q;
        pass_d       = pass_q;
        err_cnt_d    = err_cnt_q;
        fail_valid_d = fail_valid_q;
        first_fail_d = first_fail_q;
        mismatch     = bus.s_in ^ bus.t_in;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (bus.start) begin
                    state_d      = ST_DRIVE;
                    idx_d        = '0;
                    busy_d       = 1'b1;
                    done_d       = 1'b0;
                    pass_d       = 1'b0;
                    err_cnt_d    = '0;
                    fail_valid_d = 1'b0;
                    first_fail_d = '0;
                end
            end
            ST_DRIVE: begin
                if (bus.abort) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b0;
                    pass_d  = 1'b0;
                end else begin
                    state_d = ST_SAMPLE;
                end
            end
            ST_SAMPLE: begin
                if (bus.abort) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b0;
                    pass_d  = 1'b0;
                end else begin
                    if (mismatch) begin
                        err_cnt_d = err_cnt_q + ERR_ONE;
                        if (!fail_valid_q) begin
                            fail_valid_d = 1'b1;
                            first_fail_d = vec_q;
                        end
                    end
                    if (idx_q == IDX_LAST) begin
                        state_d = ST_DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        pass_d  = (err_cnt_d == '0);
                    end else begin
                        state_d = ST_DRIVE;
                        idx_d   = idx_q + IDX_ONE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b0;
                pass_d  = 1'b0;
            end
        endcase

        vec_d = idx_to_vec(idx_d);
    end

    // State and registered outputs; reset clears everything without waiting for a clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            idx_q        <= '0;
            vec_q        <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
            err_cnt_q    <= '0;
            fail_valid_q <= 1'b0;
            first_fail_q <= '0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            vec_q        <= vec_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            pass_q       <= pass_d;
            err_cnt_q    <= err_cnt_d;
            fail_valid_q <= fail_valid_d;
            first_fail_q <= first_fail_d;
        end
    end

    assign bus.vec        = vec_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.pass       = pass_q;
    assign bus.err_cnt    = err_cnt_q;
    assign bus.fail_valid = fail_valid_q;
    assign bus.first_fail = first_fail_q;

endmodule

// File: tb/tb_exh_sweep_ctrl.sv
// tb/tb_exh_sweep_ctrl.sv - directed bench for exh_sweep_ctrl (N=2), both vector orders
module tb_exh_sweep_ctrl;

    localparam int N  = 2;
    localparam int NV = 4;

    logic clk;
    logic rst_n;
    logic [3:0] fault_mask;

    int tests_run;
    int tests_failed;

    logic [N-1:0] seen [NV];
    logic         snap_busy0;
    logic [N:0]   snap_err0;
    logic         snap_fv0;
    logic [N-1:0] snap_ff0;
    int           n;
    logic [N:0]   err_hold;

    exh_sweep_ctrl_if #(.N(N)) sif ();

    exh_sweep_ctrl #(.N(N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (sif.slave)
    );

    // implementation A: direct xnor; implementation B: NOR-only rewrite with optional injected faults
    assign sif.s_in = ~(sif.vec[1] ^ sif.vec[0]);
    assign sif.t_in = ~(~(~(sif.vec[1] | sif.vec[1]) | sif.vec[0]) |
                        ~(sif.vec[1] | ~(sif.vec[0] | sif.vec[0]))) ^ fault_mask[sif.vec];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [N-1:0] exp_vec(input int k);
        logic [N-1:0] b;
        b = k[N-1:0];
`ifdef EXH_SWEEP_GRAY_EN
        return b ^ (b >> 1);
`else
        return b;
`endif
    endfunction

    function automatic int exp_err(input logic [3:0] m);
        int c;
        c = 0;
        for (int k = 0; k < NV; k++) if (m[k]) c++;
        return c;
    endfunction

    function automatic logic [N-1:0] exp_ff(input logic [3:0] m);
        for (int k = 0; k < NV; k++) if (m[exp_vec(k)]) return exp_vec(k);
        return '0;
    endfunction

    // start a sweep; optional start pulses during the sweep, abort at edge-count abort_n, and abort alongside start
    task automatic sweep(input int start_mask, input int abort_n, input bit with_abort, output int ne);
        ne = 0;
        @(negedge clk);
        sif.start = 1'b1;
        sif.abort = with_abort;
        @(posedge clk);
        @(negedge clk);
        sif.start  = 1'b0;
        sif.abort  = 1'b0;
        seen[0]    = sif.vec;
        snap_busy0 = sif.busy;
        snap_err0  = sif.err_cnt;
        snap_fv0   = sif.fail_valid;
        snap_ff0   = sif.first_fail;
        while (ne < 40) begin
            sif.start = (ne < 32) ? start_mask[ne] : 1'b0;
            sif.abort = (ne == abort_n);
            @(posedge clk);
            ne++;
            @(negedge clk);
            sif.start = 1'b0;
            sif.abort = 1'b0;
            if ((ne % 2 == 0) && (ne < 2 * NV)) seen[ne / 2] = sif.vec;
            if (sif.done || !sif.busy) break;
        end
    endtask

    task automatic check_seq(input string tag);
        for (int k = 0; k < NV; k++) check(tag, {30'd0, seen[k]}, {30'd0, exp_vec(k)});
    endtask

    task automatic check_full(input string tag, input logic [3:0] m);
        check({tag, "_cycles"}, n, 8);
        check({tag, "_done"}, {31'd0, sif.done}, 32'd1);
        check({tag, "_busy"}, {31'd0, sif.busy}, 32'd0);
        check({tag, "_err"}, {29'd0, sif.err_cnt}, exp_err(m));
        check({tag, "_pass"}, {31'd0, sif.pass}, (exp_err(m) == 0) ? 32'd1 : 32'd0);
        check({tag, "_fv"}, {31'd0, sif.fail_valid}, (exp_err(m) != 0) ? 32'd1 : 32'd0);
        check({tag, "_ff"}, {30'd0, sif.first_fail}, {30'd0, exp_ff(m)});
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst_n        = 1'b0;
        sif.start    = 1'b0;
        sif.abort    = 1'b0;
        fault_mask   = 4'b0000;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_vec", {30'd0, sif.vec}, 32'd0);
        check("rst_busy", {31'd0, sif.busy}, 32'd0);
        check("rst_done", {31'd0, sif.done}, 32'd0);
        check("rst_pass", {31'd0, sif.pass}, 32'd0);
        check("rst_err", {29'd0, sif.err_cnt}, 32'd0);
        check("rst_fv", {31'd0, sif.fail_valid}, 32'd0);
        check("rst_ff", {30'd0, sif.first_fail}, 32'd0);
        rst_n = 1'b1;

        // clean sweep
        fault_mask = 4'b0000;
        sweep(0, -1, 1'b0, n);
        check("pass_busy0", {31'd0, snap_busy0}, 32'd1);
        check_seq("pass_seq");
        check_full("pass", fault_mask);

        // faults on vectors 10 and 11
        fault_mask = 4'b1100;
        sweep(0, -1, 1'b0, n);
        check_seq("fault_seq");
        check_full("fault", fault_mask);

        // restart from DONE clears results; start pulses while busy are ignored
        fault_mask = 4'b0000;
        sweep(32'h28, -1, 1'b0, n);
        check("restart_err0", {29'd0, snap_err0}, 32'd0);
        check("restart_fv0", {31'd0, snap_fv0}, 32'd0);
        check("restart_ff0", {30'd0, snap_ff0}, 32'd0);
        check_full("busystart", fault_mask);

        // abort during SAMPLE of vector 01 which carries a fault
        fault_mask = 4'b0010;
        sweep(0, 3, 1'b0, n);
        check("abort_edges", n, 4);
        check("abort_busy", {31'd0, sif.busy}, 32'd0);
        check("abort_done", {31'd0, sif.done}, 32'd0);
        check("abort_pass", {31'd0, sif.pass}, 32'd0);
        check("abort_err", {29'd0, sif.err_cnt}, 32'd0);
        check("abort_fv", {31'd0, sif.fail_valid}, 32'd0);

        // abort while idle does nothing
        @(negedge clk);
        sif.abort = 1'b1;
        @(posedge clk);
        @(negedge clk);
        sif.abort = 1'b0;
        check("idle_abort_busy", {31'd0, sif.busy}, 32'd0);
        check("idle_abort_done", {31'd0, sif.done}, 32'd0);

        // full sweep after abort
        sweep(0, -1, 1'b0, n);
        check_seq("after_abort_seq");
        check_full("after_abort", fault_mask);

        // abort while DONE does nothing
        err_hold = sif.err_cnt;
        @(negedge clk);
        sif.abort = 1'b1;
        @(posedge clk);
        @(negedge clk);
        sif.abort = 1'b0;
        check("done_abort_done", {31'd0, sif.done}, 32'd1);
        check("done_abort_err", {29'd0, sif.err_cnt}, {29'd0, err_hold});

        // start and abort together from DONE: start wins
        fault_mask = 4'b1000;
        sweep(0, -1, 1'b1, n);
        check("startabort_busy0", {31'd0, snap_busy0}, 32'd1);
        check("startabort_err0", {29'd0, snap_err0}, 32'd0);
        check_seq("single_seq");
        check_full("single", fault_mask);

        // asynchronous reset in the middle of a sweep
        fault_mask = 4'b0001;
        @(negedge clk);
        sif.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        sif.start = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("pre_rst_busy", {31'd0, sif.busy}, 32'd1);
        check("pre_rst_err", {29'd0, sif.err_cnt}, 32'd1);
        check("pre_rst_vec", {30'd0, sif.vec}, {30'd0, exp_vec(2)});
        #1 rst_n = 1'b0;
        #1;
        check("mid_rst_vec", {30'd0, sif.vec}, 32'd0);
        check("mid_rst_busy", {31'd0, sif.busy}, 32'd0);
        check("mid_rst_err", {29'd0, sif.err_cnt}, 32'd0);
        check("mid_rst_fv", {31'd0, sif.fail_valid}, 32'd0);
        check("mid_rst_ff", {30'd0, sif.first_fail}, 32'd0);
        check("mid_rst_done", {31'd0, sif.done}, 32'd0);
        #1 rst_n = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("post_rst_busy", {31'd0, sif.busy}, 32'd0);
        check("post_rst_done", {31'd0, sif.done}, 32'd0);
        check("post_rst_vec", {30'd0, sif.vec}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/exh_sweep_ctrl.md
Name: exh_sweep_ctrl

Overview:
- Sequencer that exhaustively drives every input vector into two combinational implementations of the same function, e.g. a direct-form gate and its NOR-only rewrite.
- Compares their outputs on each vector, counts mismatches and records the first failing vector.
- Sits between a start/done host (bench or self-test logic) and the pair of function blocks under comparison.

Parameters:
- N, 2, input width of the compared functions; the sweep covers 2^N vectors (1 <= N <= 8).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  begin a sweep; sampled only in IDLE or DONE.
- abort  input  1  cancel a running sweep.
- s_in  input  1  output of implementation A.
- t_in  input  1  output of implementation B.
- vec  output  N  input vector driven to both implementations.
- busy  output  1  high while a sweep is running (DRIVE or SAMPLE).
- done  output  1  high in DONE state.
- pass  output  1  high in DONE when err_cnt == 0.
- err_cnt  output  N+1  mismatch count for the current or last sweep.
- fail_valid  output  1  at least one mismatch recorded.
- first_fail  output  N  vector of the first mismatch.

Behaviour:
- Reset is asynchronous, active-low, and takes effect mid-sweep immediately.
  - State goes to IDLE.
  - vec=0, busy=0, done=0, pass=0, err_cnt=0, fail_valid=0, first_fail=0.
- State machine: IDLE, DRIVE, SAMPLE, DONE.
- IDLE or DONE, start=1 at an edge:
  - State goes to DRIVE; vec = first vector (0).
  - err_cnt, fail_valid and first_fail are cleared; busy=1; done=pass=0.
- DRIVE: one settle cycle, then unconditionally to SAMPLE. vec is held.
- SAMPLE, at the edge leaving it:
  - Compare s_in with t_in. On mismatch, err_cnt += 1.
  - If fail_valid was 0, load first_fail=vec and set fail_valid=1.
  - If vec is the last vector, go to DONE.
  - Otherwise advance vec to the next vector and go to DRIVE.
- Latency and counter rules:
  - Each vector takes 2 cycles.
  - done rises exactly 2*2^N edges after the start edge (8 for N=2).
  - err_cnt maximum is 2^N; the width N+1 means it can never overflow.
- DONE:
  - busy=0, done=1, pass=(err_cnt==0).
  - vec and all results hold until a new start or reset.
- abort=1 in DRIVE or SAMPLE:
  - Next state is IDLE; busy=0, done=0, pass=0.
  - err_cnt, fail_valid and first_fail keep their partial values.
  - abort takes priority over the SAMPLE comparison in that cycle; the in-flight vector is not counted.
- abort in IDLE or DONE is ignored.
- start in DRIVE or SAMPLE is ignored.
- Simultaneous start and abort in IDLE or DONE: start wins.

Optional Feature:
- Macro: EXH_SWEEP_GRAY_EN.
- Defined:
  - An internal N-bit index counts 0..2^N-1 and vec = idx ^ (idx >> 1), so consecutive vectors differ by one bit.
  - The last vector is the Gray code of 2^N-1 (2'b10 for N=2).
  - first_fail reports the driven vec value, not idx.
- Undefined: vec counts in plain binary 0..2^N-1 and the last vector is all ones.
- Both modes: cycle timing is identical.

Test Plan:
- Pass case. Setup: N=2, s_in=~(a^b), t_in=~(~(~(a|a)|b)|~(a|~(b|b))) on vec={a,b}. Stimulus: pulse start. Required response:
  - vec steps 00,01,10,11.
  - done rises 8 cycles after the start edge.
  - pass=1, err_cnt=0, fail_valid=0.
- Fault injection. Setup: t_in inverted when vec==2'b10 and when vec==2'b11. Required response: done after 8 cycles, pass=0, err_cnt=2, fail_valid=1, first_fail=2'b10.
- Abort. Stimulus: start, then abort during the SAMPLE cycle of vec==2'b01, with a fault on vec 01. Required response:
  - Next state IDLE; busy=0, done=0.
  - err_cnt=0 (the vec-01 fault is not counted).
  - A following start completes a full 8-cycle sweep.
- Reset mid-sweep. Stimulus: rst_n low during vec==2'b10 for a sub-cycle pulse. Required response: all outputs zero immediately, without waiting for clk; state IDLE.
- Start while busy. Stimulus: start pulses in cycles 3 and 5 of a sweep. Required response: ignored; done still at cycle 8. Restart from DONE clears err_cnt and first_fail.
- Gray mode. Setup: compiled with EXH_SWEEP_GRAY_EN, N=2, fault only on vec 2'b11. Required response:
  - vec steps 00,01,11,10.
  - first_fail=2'b11, err_cnt=1, done at cycle 8.
